// File: rtl/sram_block_responder.sv
// sram_block_responder: target end of the wide block-SRAM port.
// Accepts one-block read/write requests on a wide bus and serialises them
// onto a narrow single-port SRAM, one word per cycle. Read blocks are
// returned with a one-cycle valid pulse; write completion is signalled by
// a one-cycle done pulse.
module sram_block_responder #(
  parameter  int ADDR_SIZE_BITS  = 24,
  parameter  int WORD_SIZE_BYTES = 3,
  parameter  int DATA_SIZE_WORDS = 64,
  localparam int WORD_BITS       = 8 * WORD_SIZE_BYTES,
  localparam int BLOCK_BITS      = WORD_BITS * DATA_SIZE_WORDS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      read_enable,
  input  logic                      write_enable,
  input  logic [ADDR_SIZE_BITS-1:0] address,
  input  logic [BLOCK_BITS-1:0]     write_data,
  output logic [BLOCK_BITS-1:0]     read_data,
  output logic                      rd_valid,
  output logic                      wr_done,
  output logic                      busy,
  output logic [ADDR_SIZE_BITS-1:0] mem_addr,
  output logic                      mem_re,
  output logic                      mem_we,
  output logic [WORD_BITS-1:0]      mem_wdata,
  input  logic [WORD_BITS-1:0]      mem_rdata
);

  localparam int               CNT_W = $clog2(DATA_SIZE_WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_SIZE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_LAST,
    S_RD_DONE,
    S_WR,
    S_WR_DONE
  } state_t;

  state_t                         r_state;
  logic [CNT_W-1:0]               r_cnt;
  logic [ADDR_SIZE_BITS-1:0]      r_base;
  logic [BLOCK_BITS-1:0]          r_wbuf;
  // The final word is merged straight into read_data, so it is not buffered.
  logic [BLOCK_BITS-WORD_BITS-1:0] r_rbuf;
  logic [BLOCK_BITS-1:0]          r_read_data;
  logic                           r_rd_valid;
  logic                           r_wr_done;
  logic [ADDR_SIZE_BITS-1:0]      r_mem_addr;
  logic                           r_mem_re;
  logic                           r_mem_we;
  logic [WORD_BITS-1:0]           r_mem_wdata;

  logic [CNT_W-1:0]               w_cnt_nxt;
  logic [CNT_W-1:0]               w_cap_idx;
  logic [ADDR_SIZE_BITS-1:0]      w_addr_nxt;
  logic [WORD_BITS-1:0]           w_wword_nxt;

  // Next word index, its address (wraps modulo 2^ADDR) and write word; the
  // read capture index lags the issue index by one for the SRAM latency.
  always_comb begin
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_cap_idx   = r_cnt - CNT_W'(1);
    w_addr_nxt  = r_base + ADDR_SIZE_BITS'(w_cnt_nxt);
    w_wword_nxt = r_wbuf[w_cnt_nxt*WORD_BITS +: WORD_BITS];
  end

  // Transfer sequencer with registered SRAM strobes and completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_base      <= '0;
      r_wbuf      <= '0;
      r_rbuf      <= '0;
      r_read_data <= '0;
      r_rd_valid  <= 1'b0;
      r_wr_done   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      r_wr_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (write_enable) begin
            r_state     <= S_WR;
            r_base      <= address;
            r_wbuf      <= write_data;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= address;
            r_mem_wdata <= write_data[WORD_BITS-1:0];
          end else if (read_enable) begin
            r_state    <= S_RD;
            r_base     <= address;
            r_mem_re   <= 1'b1;
            r_mem_addr <= address;
          end
        end
        S_WR: begin
          if (r_cnt == LAST) begin
            r_state     <= S_WR_DONE;
            r_cnt       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wr_done   <= 1'b1;
          end else begin
            r_cnt       <= w_cnt_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wword_nxt;
          end
        end
        S_WR_DONE: r_state <= S_IDLE;
        S_RD: begin
          if (r_cnt != '0) begin
            r_rbuf[w_cap_idx*WORD_BITS +: WORD_BITS] <= mem_rdata;
          end
          if (r_cnt == LAST) begin
            r_state    <= S_RD_LAST;
            r_cnt      <= '0;
            r_mem_re   <= 1'b0;
            r_mem_addr <= '0;
          end else begin
            r_cnt      <= w_cnt_nxt;
            r_mem_addr <= w_addr_nxt;
          end
        end
        S_RD_LAST: begin
          r_state     <= S_RD_DONE;
          r_read_data <= {mem_rdata, r_rbuf};
          r_rd_valid  <= 1'b1;
        end
        S_RD_DONE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign read_data = r_read_data;
  assign rd_valid  = r_rd_valid;
  assign wr_done   = r_wr_done;
  assign busy      = (r_state != S_IDLE);
  assign mem_addr  = r_mem_addr;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_sram_block_responder.sv
// tb_sram_block_responder: scoreboard bench for sram_block_responder.
// Stimulus pushes expected SRAM accesses and completions; a negedge monitor
// pops and compares whenever the DUT presents them.
module tb_sram_block_responder;

  localparam int AW = 24;
  localparam int WB = 24;
  localparam int NW = 64;
  localparam int BW = WB * NW;
  localparam logic [WB-1:0] KEY = 24'hA5A5A5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          read_enable = 1'b0;
  logic          write_enable = 1'b0;
  logic [AW-1:0] address = '0;
  logic [BW-1:0] write_data = '0;
  logic [BW-1:0] read_data;
  logic          rd_valid;
  logic          wr_done;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [WB-1:0] mem_wdata;
  logic [WB-1:0] mem_rdata = '0;

  sram_block_responder #(
    .ADDR_SIZE_BITS (AW),
    .WORD_SIZE_BYTES(3),
    .DATA_SIZE_WORDS(NW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .read_enable (read_enable),
    .write_enable(write_enable),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .rd_valid    (rd_valid),
    .wr_done     (wr_done),
    .busy        (busy),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [WB-1:0] data;
    int            cyc;
  } mem_ev_t;

  typedef struct {
    logic [BW-1:0] blk;
    int            cyc;
  } rd_ev_t;

  mem_ev_t       exp_mem[$];
  rd_ev_t        exp_rd[$];
  int            exp_wr[$];
  logic [BW-1:0] rd_shadow = '0;
  int            busy_lo = -1;
  int            busy_hi = -2;
  bit            mon_en = 1'b0;

  // Reference memory (what the SRAM should hold) and physical SRAM stub.
  logic [WB-1:0] ref_mem [logic [AW-1:0]];
  logic [WB-1:0] phys_mem[logic [AW-1:0]];

  function automatic logic [WB-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ KEY);
  endfunction

  function automatic logic [WB-1:0] phys_rd(input logic [AW-1:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : (a ^ KEY);
  endfunction

  // Physical SRAM: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (mem_we) phys_mem[mem_addr] = mem_wdata;
    if (mem_re) mem_rdata <= phys_rd(mem_addr);
    else        mem_rdata <= WB'($urandom);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      int k0 = 0;
      for (int k = NW - 1; k >= 0; k--)
        if (act[k*WB +: WB] !== exp[k*WB +: WB]) k0 = k;
      errors++;
      $display("FAIL %s: word %0d got %06h expected %06h at cycle %0d",
               nm, k0, act[k0*WB +: WB], exp[k0*WB +: WB], cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin : mon
    mem_ev_t e;
    rd_ev_t  r;
    int      w;
    if (mon_en) begin
      chk("strobe_excl", 64'(mem_re & mem_we), 64'd0);
      chk("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
      if (mem_we || mem_re) begin
        if (exp_mem.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got we=%0b re=%0b addr %06h expected no access at cycle %0d",
                   mem_we, mem_re, mem_addr, cyc);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_cycle", 64'(cyc), 64'(e.cyc));
          chk("mem_we", 64'(mem_we), 64'(e.we));
          chk("mem_re", 64'(mem_re), 64'(!e.we));
          chk("mem_addr", 64'(mem_addr), 64'(e.addr));
          chk("mem_wdata", 64'(mem_wdata), 64'(e.data));
        end
      end else begin
        chk("idle_addr", 64'(mem_addr), 64'd0);
        chk("idle_wdata", 64'(mem_wdata), 64'd0);
      end
      if (wr_done) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr_done: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_done_cycle", 64'(cyc), 64'(w));
        end
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd_valid: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          r = exp_rd.pop_front();
          chk("rd_valid_cycle", 64'(cyc), 64'(r.cyc));
          chk_blk("read_data", read_data, r.blk);
          rd_shadow = r.blk;
        end
      end else begin
        chk_blk("read_data_hold", read_data, rd_shadow);
      end
    end
  end

  // Drive one request for a single cycle and queue its expected effects.
  task automatic issue(input logic we, input logic re, input logic [AW-1:0] base,
                       input logic [BW-1:0] data, input int n_ev, input bit done_ev);
    int            t;
    logic [BW-1:0] blk;
    logic [AW-1:0] a;
    write_enable = we;
    read_enable  = re;
    address      = base;
    write_data   = data;
    t            = cyc;
    busy_lo      = t + 1;
    blk          = '0;
    if (we) begin
      for (int k = 0; k < NW; k++) begin
        a = base + AW'(k);
        if (k < n_ev) exp_mem.push_back('{1'b1, a, data[k*WB +: WB], t + 1 + k});
        ref_mem[a] = data[k*WB +: WB];
      end
      busy_hi = t + 65;
      if (done_ev) exp_wr.push_back(t + 65);
    end else if (re) begin
      for (int k = 0; k < NW; k++) begin
        a = base + AW'(k);
        blk[k*WB +: WB] = ref_rd(a);
        if (k < n_ev) exp_mem.push_back('{1'b0, a, '0, t + 1 + k});
      end
      busy_hi = t + 66;
      if (done_ev) exp_rd.push_back('{blk, t + 66});
    end
    @(posedge clk); #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected 0 within 300 cycles at cycle %0d", cyc);
    end
    chk("drain", 64'(exp_mem.size() + exp_rd.size() + exp_wr.size()), 64'd0);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [BW-1:0] d;
    logic [AW-1:0] base;
    logic [AW-1:0] last_wr = 24'h000040;
    int            op;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_blk("rst_read_data", read_data, '0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_wr_done", 64'(wr_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_re", 64'(mem_re), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Write block, word k = k+1
    for (int k = 0; k < NW; k++) d[k*WB +: WB] = WB'(k + 1);
    issue(1'b1, 1'b0, 24'h000040, d, NW, 1'b1);
    wait_idle();

    // Read from unwritten region
    issue(1'b0, 1'b1, 24'h010000, '0, NW, 1'b1);
    wait_idle();
    gap(5);

    // Read back the first write
    issue(1'b0, 1'b1, 24'h000040, '0, NW, 1'b1);
    wait_idle();

    // Both enables: write wins, read dropped
    for (int k = 0; k < NW; k++) d[k*WB +: WB] = WB'($urandom);
    issue(1'b1, 1'b1, 24'h000200, d, NW, 1'b1);
    wait_idle();

    // Wrapping write with an ignored request pulsed mid-transfer
    for (int k = 0; k < NW; k++) d[k*WB +: WB] = WB'($urandom);
    issue(1'b1, 1'b0, 24'hFFFFF0, d, NW, 1'b1);
    gap(9);
    write_enable = 1'b1;
    read_enable  = 1'b1;
    address      = 24'h123456;
    write_data   = ~d;
    gap(1);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    wait_idle();
    issue(1'b0, 1'b1, 24'hFFFFF0, '0, NW, 1'b1);
    wait_idle();

    // Reset in the middle of a read
    issue(1'b0, 1'b1, 24'h000300, '0, 30, 1'b0);
    gap(29);
    rst     = 1'b1;
    busy_hi = cyc;
    gap(1);
    rst       = 1'b0;
    rd_shadow = '0;
    chk_blk("abort_read_data", read_data, '0);
    chk("abort_mem_re", 64'(mem_re), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rd_valid", 64'(rd_valid), 64'd0);
    gap(3);
    chk("abort_drain", 64'(exp_mem.size() + exp_rd.size() + exp_wr.size()), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 16; n++) begin
      gap($urandom_range(0, 3));
      op = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       base = 24'hFFFFFF - AW'($urandom_range(0, 70));
        1:       base = last_wr + AW'($urandom_range(0, 32));
        default: base = AW'($urandom);
      endcase
      for (int k = 0; k < NW; k++) d[k*WB +: WB] = WB'($urandom);
      if (op != 1) last_wr = base;
      issue(op != 1, op != 0, base, d, NW, 1'b1);
      wait_idle();
    end

    gap(4);
    chk("final_drain", 64'(exp_mem.size() + exp_rd.size() + exp_wr.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
